// File: rtl/aes_pkg.sv
// aes_pkg -- shared widths for the AES datapath blocks.
//   BYTE_W  : width of one AES state byte
//   N_BYTES : bytes in one AES block
//   BLOCK_W : width of one AES block
//   CNT_W   : width of a byte counter that indexes one block
package aes_pkg;

  localparam int BYTE_W  = 8;
  localparam int N_BYTES = 16;
  localparam int BLOCK_W = BYTE_W * N_BYTES;
  localparam int CNT_W   = $clog2(N_BYTES);

endpackage

// File: rtl/block_assembler_8to128.sv
// block_assembler_8to128 -- packs a byte stream into 128-bit AES blocks.
//
// The first accepted byte of a block lands in the most significant byte of
// out_block (AES byte 0). A completed block goes straight to the output
// register when that register is free or being consumed. Otherwise it waits
// in the fill buffer as a pending block, and in_ready drops until the output
// register takes it. At most two blocks are buffered.
//
// Ports
//   clk       : clock, all state on the rising edge
//   reset     : asynchronous active-high reset
//   clear     : synchronous discard of the partial or pending block in the
//               fill buffer; the output register is left alone
//   in_valid  : in_byte is presented this cycle
//   in_byte   : input byte, BYTE_W bits
//   in_ready  : a byte is accepted when in_valid && in_ready
//   out_valid : out_block holds a complete block
//   out_block : assembled block, BYTE_W*N_BYTES bits
//   out_ready : a block is consumed when out_valid && out_ready
//
// N_BYTES must be a power of two and at least 2, so the fill counter wraps
// naturally after the last byte.
module block_assembler_8to128 #(
  parameter int BYTE_W  = aes_pkg::BYTE_W,
  parameter int N_BYTES = aes_pkg::N_BYTES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clear,
  input  logic                      in_valid,
  input  logic [BYTE_W-1:0]         in_byte,
  output logic                      in_ready,
  output logic                      out_valid,
  output logic [BYTE_W*N_BYTES-1:0] out_block,
  input  logic                      out_ready
);

  localparam int BLK_W = BYTE_W * N_BYTES;
  localparam int CNT_W = $clog2(N_BYTES);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_BYTES - 1);

  logic [BLK_W-1:0] fill;
  logic [BLK_W-1:0] fill_next;
  logic [CNT_W-1:0] cnt;
  logic             pending;

  logic accept;
  logic last_byte;
  logic out_free;
  logic load_new;
  logic load_pend;

  assign in_ready  = !pending;
  assign accept    = in_valid && in_ready && !clear;
  assign last_byte = accept && (cnt == LAST_IDX);
  assign out_free  = !out_valid || out_ready;

  // Shifting in at the LSB end leaves the first byte of the block at the
  // MSB once all N_BYTES have arrived.
  assign fill_next = {fill[BLK_W-BYTE_W-1:0], in_byte};

  assign load_new  = last_byte && out_free;
  // A pending block is dropped by clear, so it must not also be loaded.
  assign load_pend = pending && out_ready && !clear;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fill      <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      out_valid <= 1'b0;
      out_block <= '0;
    end else begin
      if (clear) begin
        fill    <= '0;
        cnt     <= '0;
        pending <= 1'b0;
      end else if (accept) begin
        fill <= fill_next;
        cnt  <= cnt + CNT_W'(1);
        if (last_byte && !out_free) begin
          pending <= 1'b1;
        end
      end else if (load_pend) begin
        pending <= 1'b0;
      end

      if (load_new) begin
        out_block <= fill_next;
      end else if (load_pend) begin
        out_block <= fill;
      end

      if (load_new || load_pend) begin
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_block_assembler_8to128.sv
module tb_block_assembler_8to128;

  logic         clk;
  logic         reset;
  logic         clear;
  logic         in_valid;
  logic [7:0]   in_byte;
  logic         in_ready;
  logic         out_valid;
  logic [127:0] out_block;
  logic         out_ready;

  int n_chk;
  int n_fail;
  int n_cons;

  block_assembler_8to128 dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_block (out_block),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: inputs change on the falling edge, outputs are read 1 time
  // unit after the following rising edge.
  task automatic step(input logic c, input logic v, input logic [7:0] b, input logic r);
    @(negedge clk);
    clear     = c;
    in_valid  = v;
    in_byte   = b;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] seq_blk(input logic [7:0] start);
    logic [127:0] blk;
    blk = '0;
    for (int k = 0; k < 16; k++) blk[127-8*k -: 8] = start + 8'(k);
    return blk;
  endfunction

  // Reference model: a list of complete blocks held by the block (at most
  // two) and the bytes of the block being collected.
  logic [127:0] mq[$];
  logic [7:0]   part[$];
  int           m_pre;
  bit           m_acc;
  bit           m_cons;
  logic [127:0] m_blk;

  always begin
    @(posedge clk);
    #1;
    if (reset) begin
      mq.delete();
      part.delete();
    end else begin
      m_pre  = mq.size();
      m_acc  = in_valid && !clear && (m_pre < 2);
      m_cons = out_ready && (m_pre > 0);
      if (clear) begin
        part.delete();
        if (m_pre == 2) void'(mq.pop_back());
      end
      if (m_cons) begin
        void'(mq.pop_front());
        n_cons++;
      end
      if (m_acc) begin
        part.push_back(in_byte);
        if (part.size() == 16) begin
          m_blk = '0;
          for (int k = 0; k < 16; k++) m_blk[127-8*k -: 8] = part[k];
          mq.push_back(m_blk);
          part.delete();
        end
      end
      chk("model_in_ready", 128'(in_ready), 128'(mq.size() < 2));
      chk("model_out_valid", 128'(out_valid), 128'(mq.size() > 0));
      if (mq.size() > 0) chk("model_out_block", out_block, mq[0]);
    end
  end

  typedef struct {
    logic         clr;
    logic         iv;
    logic [7:0]   b;
    logic         ordy;
    logic         exp_irdy;
    logic         exp_ov;
    logic [127:0] exp_blk;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(input logic c, input logic v, input logic [7:0] b, input logic r,
                              input logic ov, input logic [127:0] blk);
    vec_t t;
    t.clr      = c;
    t.iv       = v;
    t.b        = b;
    t.ordy     = r;
    t.exp_irdy = 1'b1;
    t.exp_ov   = ov;
    t.exp_blk  = blk;
    return t;
  endfunction

  initial begin
    int base;
    int cyc;

    n_chk     = 0;
    n_fail    = 0;
    n_cons    = 0;
    reset     = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    out_ready = 1'b0;

    // Bytes 0x00..0x0F back-to-back, then consume; then bytes 0..2, a clear
    // colliding with byte 3, and a fresh block 0x40..0x4F.
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(1'b0, 1'b1, 8'(i), 1'b1, i == 15, 128'h000102030405060708090a0b0c0d0e0f));
    vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, '0));
    for (int i = 0; i < 3; i++)
      vt.push_back(mk(1'b0, 1'b1, 8'(i), 1'b1, 1'b0, '0));
    vt.push_back(mk(1'b1, 1'b1, 8'h03, 1'b1, 1'b0, '0));
    for (int i = 0; i < 16; i++)
      vt.push_back(mk(1'b0, 1'b1, 8'h40 + 8'(i), 1'b1, i == 15, 128'h404142434445464748494a4b4c4d4e4f));
    vt.push_back(mk(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, '0));

    #1;
    chk("reset_in_ready", 128'(in_ready), 128'(1));
    chk("reset_out_valid", 128'(out_valid), 128'(0));
    chk("reset_out_block", out_block, 128'(0));
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vt[i]) begin
      step(vt[i].clr, vt[i].iv, vt[i].b, vt[i].ordy);
      chk($sformatf("vec%0d_in_ready", i), 128'(in_ready), 128'(vt[i].exp_irdy));
      chk($sformatf("vec%0d_out_valid", i), 128'(out_valid), 128'(vt[i].exp_ov));
      if (vt[i].exp_ov) chk($sformatf("vec%0d_out_block", i), out_block, vt[i].exp_blk);
    end

    // Two blocks with the output stalled, then one out_ready pulse.
    for (int i = 0; i < 32; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    chk("stall_in_ready", 128'(in_ready), 128'(0));
    chk("stall_out_valid", 128'(out_valid), 128'(1));
    chk("stall_out_block", out_block, seq_blk(8'h00));
    step(1'b0, 1'b1, 8'hee, 1'b0);
    chk("stall_drop_in_ready", 128'(in_ready), 128'(0));
    chk("stall_hold_block", out_block, seq_blk(8'h00));
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pend_out_valid", 128'(out_valid), 128'(1));
    chk("pend_out_block", out_block, seq_blk(8'h10));
    chk("pend_in_ready", 128'(in_ready), 128'(1));
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("drain_out_valid", 128'(out_valid), 128'(0));

    // Five bytes, clear, then 0xA0..0xAF.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'ha0 + 8'(i), 1'b0);
    chk("clear_out_valid", 128'(out_valid), 128'(1));
    chk("clear_out_block", out_block, seq_blk(8'ha0));
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("clear_drain", 128'(out_valid), 128'(0));

    // Reset with a held block and 9 bytes of the next one in flight.
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'h60 + 8'(i), 1'b0);
    for (int i = 0; i < 9; i++) step(1'b0, 1'b1, 8'h70 + 8'(i), 1'b0);
    #2;
    in_valid = 1'b0;
    reset    = 1'b1;
    #1;
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_out_block", out_block, 128'(0));
    chk("midrst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 8'hc0 + 8'(i), 1'b0);
    chk("postrst_out_valid", 128'(out_valid), 128'(1));
    chk("postrst_out_block", out_block, seq_blk(8'hc0));
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Random traffic until 1000 blocks have been consumed.
    base = n_cons;
    cyc  = 0;
    while ((n_cons - base) < 1000 && cyc < 60000) begin
      step($urandom_range(0, 499) == 0, $urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 3) != 0);
      cyc++;
    end
    chk("rand_1000_blocks", 128'((n_cons - base) >= 1000), 128'(1));

    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("final_out_valid", 128'(out_valid), 128'(0));
    chk("final_in_ready", 128'(in_ready), 128'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
